// File: rtl/reg_dump_reader.sv
// Walks the register file through a spare read port and streams each
// (index, value) pair out over a valid/ready handshake for post-mortem dumps.
module reg_dump_reader #(
    parameter int NUM_REGS  = 32,
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int SKIP_ZERO = 0
) (
    input  logic              Clock,
    input  logic              Clear_n,
    input  logic              Start,
    input  logic              Abort,
    output logic [ADDR_W-1:0] RdAddr,
    input  logic [DATA_W-1:0] RdData,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [ADDR_W-1:0] OutIndex,
    output logic [DATA_W-1:0] OutData,
    output logic              Busy,
    output logic              Done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] FIRST_IDX = (SKIP_ZERO != 0) ? ADDR_W'(1) : ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ONE_IDX   = ADDR_W'(1);

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   idx_reg, idx_next;
    logic [ADDR_W-1:0]   rd_addr_reg, rd_addr_next;
    logic                out_valid_reg, out_valid_next;
    logic [ADDR_W-1:0]   out_index_reg, out_index_next;
    logic [DATA_W-1:0]   out_data_reg, out_data_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;
    logic                handshake;

    assign handshake = out_valid_reg & OutReady;

    always_ff @(posedge Clock or negedge Clear_n) begin
        if (!Clear_n) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= '0;
            rd_addr_reg   <= '0;
            out_valid_reg <= 1'b0;
            out_index_reg <= '0;
            out_data_reg  <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            rd_addr_reg   <= rd_addr_next;
            out_valid_reg <= out_valid_next;
            out_index_reg <= out_index_next;
            out_data_reg  <= out_data_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        out_valid_next = out_valid_reg;
        out_index_next = out_index_reg;
        out_data_next  = out_data_reg;

        case (state_reg)
            ST_IDLE: begin
                out_valid_next = 1'b0;
                if (Start) begin
                    idx_next   = FIRST_IDX;
                    state_next = ST_READ;
                end
            end
            ST_READ: begin
                if (Abort) begin
                    out_valid_next = 1'b0;
                    state_next     = ST_IDLE;
                end else begin
                    out_data_next  = RdData;
                    out_index_next = idx_reg;
                    out_valid_next = 1'b1;
                    state_next     = ST_SEND;
                end
            end
            ST_SEND: begin
                // A word accepted on the abort edge is still delivered; only the walk stops.
                if (Abort) begin
                    out_valid_next = 1'b0;
                    state_next     = ST_IDLE;
                end else if (handshake) begin
                    out_valid_next = 1'b0;
                    if (idx_reg == LAST_IDX) begin
                        state_next = ST_DONE;
                    end else begin
                        idx_next   = idx_reg + ONE_IDX;
                        state_next = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                out_valid_next = 1'b0;
                state_next     = ST_IDLE;
            end
            default: begin
                out_valid_next = 1'b0;
                state_next     = ST_IDLE;
            end
        endcase

        // Registered outputs are derived from the state being entered so they line up with it.
        rd_addr_next = (state_next == ST_READ) ? idx_next : '0;
        busy_next    = (state_next != ST_IDLE);
        done_next    = (state_next == ST_DONE);
    end

    assign RdAddr   = rd_addr_reg;
    assign OutValid = out_valid_reg;
    assign OutIndex = out_index_reg;
    assign OutData  = out_data_reg;
    assign Busy     = busy_reg;
    assign Done     = done_reg;

endmodule
